tile_feeder: RTL and testbench

Transmit-side companion of the 5x5 systolic tile. It accepts one fmap vector (ROWS lanes) and one weight vector (COLS lanes) per beat over a valid/ready handshake, and applies the diagonal skew the array requires. It drives the tile's `i_fmap`, `i_weight` and `i_en_tf` inputs. Each pass consists of a programmed number of beats followed by a zero-filled flush, so the last operands traverse the whole array, and ends with a one-cycle done pulse.

---
 rtl/tile_feeder.sv | 172 +++++++++++++++++
 tb/tb_tile_feeder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_feeder.sv
// tile_feeder: transmit-side skew feeder for the 5x5 systolic tile.
//
// Accepts one unskewed fmap vector (ROWS lanes) and one weight vector
// (COLS lanes) per beat over a valid/ready handshake. It delays lane r/c by
// r/c cycles so that operands meet on the array diagonal. It drives the tile's
// fmap, weight and enable inputs. A pass is i_k_len beats followed by a
// zero-filled flush of ROWS+COLS-1 cycles, then a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   i_start         pass start pulse, honoured only when idle
//   i_k_len         number of beats in the pass, latched on accepted start
//   s_valid/s_ready input beat handshake
//   s_fmap/s_weight unskewed input vectors, lane n at [n*BW +: BW]
//   o_fmap/o_weight skewed, registered vectors to the tile
//   o_en_tf         tile enable (feeding or flushing)
//   o_busy          pass in progress
//   o_done          one-cycle end-of-pass pulse
//   o_bubble_cnt    (only with TILE_FEEDER_BUBBLE_CNT_EN) count of feed
//                   cycles without a transfer, saturating at 16'hFFFF
//
// Optional feature macro: TILE_FEEDER_BUBBLE_CNT_EN

module tile_feeder #(
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int K_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [K_W-1:0]         i_k_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [I_F_BW*ROWS-1:0] s_fmap,
  input  logic [W_BW*COLS-1:0]   s_weight,
  output logic [I_F_BW*ROWS-1:0] o_fmap,
  output logic [W_BW*COLS-1:0]   o_weight,
  output logic                   o_en_tf,
  output logic                   o_busy,
  output logic                   o_done
`ifdef TILE_FEEDER_BUBBLE_CNT_EN
  ,
  output logic [15:0]            o_bubble_cnt
`endif
);

  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FL_W      = $clog2(FLUSH_LEN + 1);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [K_W-1:0]    k_len_q;
  logic [K_W-1:0]    beat_cnt;
  logic [FL_W-1:0]   flush_cnt;
  logic              xfer;
  logic              start_ok;
  logic              last_beat;
  logic              flush_end;
  logic [I_F_BW*ROWS-1:0] fmap_head;
  logic [W_BW*COLS-1:0]   weight_head;

  assign xfer      = s_valid && s_ready;
  assign start_ok  = (state == IDLE) && i_start;
  // k_len_q is never zero while in FEED, so the decrement cannot wrap.
  assign last_beat = xfer && (beat_cnt == (k_len_q - K_W'(1)));
  assign flush_end = (flush_cnt == FLUSH_LAST);

  // Anything other than an accepted beat feeds zeros into the chain heads:
  // bubbles in FEED and the flush/idle drain all contribute nothing.
  assign fmap_head   = xfer ? s_fmap   : '0;
  assign weight_head = xfer ? s_weight : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. A zero-length pass goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_start) state_nxt = (i_k_len != '0) ? FEED : DONE;
      FEED:  if (last_beat) state_nxt = FLUSH;
      FLUSH: if (flush_end) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode the state only.
  always_comb begin
    s_ready = (state == FEED);
    o_en_tf = (state == FEED) || (state == FLUSH);
    o_busy  = (state != IDLE);
    o_done  = (state == DONE);
  end

  // Pass length capture, beat counting and flush timing. The flush counter
  // sits at zero outside FLUSH so every flush starts from a clean count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (start_ok) begin
        k_len_q  <= i_k_len;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + K_W'(1);
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + FL_W'(1);
      else                flush_cnt <= '0;
    end
  end

  // Per-lane skew chains: lane n is a shift register of n+1 stages whose top
  // stage is the output register. The chains run every cycle, never gated.
  for (genvar r = 0; r < ROWS; r++) begin : g_fmap
    logic [(r+1)*I_F_BW-1:0] sr;
    if (r == 0) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= fmap_head[0 +: I_F_BW];
      end
    end else begin : g_chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[r*I_F_BW-1:0], fmap_head[r*I_F_BW +: I_F_BW]};
      end
    end
    assign o_fmap[r*I_F_BW +: I_F_BW] = sr[r*I_F_BW +: I_F_BW];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_weight
    logic [(c+1)*W_BW-1:0] sr;
    if (c == 0) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= weight_head[0 +: W_BW];
      end
    end else begin : g_chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[c*W_BW-1:0], weight_head[c*W_BW +: W_BW]};
      end
    end
    assign o_weight[c*W_BW +: W_BW] = sr[c*W_BW +: W_BW];
  end

`ifdef TILE_FEEDER_BUBBLE_CNT_EN
  // Feed-cycle stall counter: cleared by an accepted start, saturating, and
  // left holding after the pass so software can read it afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_bubble_cnt <= '0;
    end else if (start_ok) begin
      o_bubble_cnt <= '0;
    end else if ((state == FEED) && !s_valid && (o_bubble_cnt != 16'hFFFF)) begin
      o_bubble_cnt <= o_bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_feeder.sv
// tb_tile_feeder: self-checking bench for tile_feeder (default 5x5, 8-bit).
// Cycle j of a pass is the clock period after the j-th rising edge since the
// start cycle; inputs are driven and outputs sampled 1 time unit after each
// rising edge.

module tb_tile_feeder;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int FL   = ROWS + COLS - 1;
  localparam int PMAX = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_k_len = '0;
  logic        s_valid = 1'b0;
  logic [39:0] s_fmap = '0;
  logic [39:0] s_weight = '0;
  logic        s_ready;
  logic [39:0] o_fmap;
  logic [39:0] o_weight;
  logic        o_en_tf;
  logic        o_busy;
  logic        o_done;
`ifdef TILE_FEEDER_BUBBLE_CNT_EN
  logic [15:0] o_bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  k;
    logic [15:0] vmask;
    int          done_off;
    int          en_cycles;
    int          rdy_cycles;
    int          bubbles;
  } vec_t;

  vec_t vecs[8];

  // Per-pass plan for the random test: driven inputs and expected values.
  logic        pst[PMAX];
  logic [7:0]  pk[PMAX];
  logic        pv[PMAX];
  logic [39:0] pf[PMAX];
  logic [39:0] pw[PMAX];
  logic [39:0] hf[PMAX];
  logic [39:0] hw[PMAX];
  logic [3:0]  ectl[PMAX];

  always #5 clk = ~clk;

  tile_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_k_len  (i_k_len),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_fmap   (s_fmap),
    .s_weight (s_weight),
    .o_fmap   (o_fmap),
    .o_weight (o_weight),
    .o_en_tf  (o_en_tf),
    .o_busy   (o_busy),
    .o_done   (o_done)
`ifdef TILE_FEEDER_BUBBLE_CNT_EN
    ,
    .o_bubble_cnt (o_bubble_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [7:0] k, input logic v,
                               input logic [39:0] f, input logic [39:0] w);
    i_start  = st;
    i_k_len  = k;
    s_valid  = v;
    s_fmap   = f;
    s_weight = w;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] rand40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  // Builds the expected timeline of one pass from the pass rules: feed until
  // k beats have been accepted, FL flush cycles, one done cycle, then idle.
  // Expected lane n of the output in cycle j is the chain head of cycle j-1-n.
  task automatic runRandomPass();
    int k, j, beats, done_j, last, bubbles;
    logic [39:0] ef, ew;
    k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
    for (int i = 0; i < PMAX; i++) begin
      pst[i] = 1'b0; pk[i] = '0; pv[i] = 1'b0; pf[i] = '0; pw[i] = '0;
      hf[i] = '0; hw[i] = '0; ectl[i] = '0;
    end
    for (int i = 0; i < PMAX; i++) begin
      pf[i] = rand40();
      pw[i] = rand40();
      pv[i] = 1'($urandom_range(0, 1));
      pk[i] = 8'($urandom_range(0, 255));
    end
    pst[0] = 1'b1;
    pk[0]  = 8'(k);
    bubbles = 0;
    j = 1;
    beats = 0;
    while (beats < k) begin
      ectl[j] = 4'b1110;
      pv[j] = (j > 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (pv[j]) begin
        beats++;
        hf[j] = pf[j];
        hw[j] = pw[j];
      end else begin
        bubbles++;
      end
      j++;
    end
    for (int f = 0; f < ((k == 0) ? 0 : FL); f++) begin
      ectl[j] = 4'b0110;
      j++;
    end
    done_j = j;
    ectl[done_j] = 4'b0011;
    last = done_j + 1;
    for (int i = 1; i < last; i++) pst[i] = ($urandom_range(0, 4) == 0);
    pst[last] = 1'b0;

    for (int jj = 0; jj <= last; jj++) begin
      applyStimulus(pst[jj], pk[jj], pv[jj], pf[jj], pw[jj]);
      ef = '0;
      ew = '0;
      for (int n = 0; n < 5; n++) begin
        if (jj - 1 - n >= 0) begin
          ef[n*8 +: 8] = hf[jj-1-n][n*8 +: 8];
          ew[n*8 +: 8] = hw[jj-1-n][n*8 +: 8];
        end
      end
      checkOutput("rnd_ctl", {s_ready, o_en_tf, o_busy, o_done}, ectl[jj]);
      checkOutput("rnd_fmap", o_fmap, ef);
      checkOutput("rnd_weight", o_weight, ew);
      tick;
    end
`ifdef TILE_FEEDER_BUBBLE_CNT_EN
    checkOutput("rnd_bubbles", o_bubble_cnt, bubbles);
`else
    if (bubbles < 0) $display("[TB] unexpected bubble count");
`endif
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{k: 8'd3, vmask: 16'hFFFF, done_off: 13, en_cycles: 12, rdy_cycles: 3, bubbles: 0};
    vecs[1] = '{k: 8'd2, vmask: 16'h0005, done_off: 13, en_cycles: 12, rdy_cycles: 3, bubbles: 1};
    vecs[2] = '{k: 8'd2, vmask: 16'h0003, done_off: 12, en_cycles: 11, rdy_cycles: 2, bubbles: 0};
    vecs[3] = '{k: 8'd0, vmask: 16'hFFFF, done_off: 1,  en_cycles: 0,  rdy_cycles: 0, bubbles: 0};
    vecs[4] = '{k: 8'd1, vmask: 16'h0001, done_off: 11, en_cycles: 10, rdy_cycles: 1, bubbles: 0};
    vecs[5] = '{k: 8'd2, vmask: 16'h0009, done_off: 14, en_cycles: 13, rdy_cycles: 4, bubbles: 2};
    vecs[6] = '{k: 8'd4, vmask: 16'h0036, done_off: 16, en_cycles: 15, rdy_cycles: 6, bubbles: 2};
    vecs[7] = '{k: 8'd5, vmask: 16'h00FE, done_off: 16, en_cycles: 15, rdy_cycles: 6, bubbles: 1};

    // Reset held with start and valid asserted: everything stays quiet.
    applyStimulus(1'b1, 8'd5, 1'b1, 40'hFFFF_FFFF_FF, 40'hFFFF_FFFF_FF);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("reset_outputs",
                  {o_fmap, o_weight, s_ready, o_en_tf, o_busy, o_done}, '0);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    rst = 1'b0;
    tick;
    checkOutput("post_reset_idle", {s_ready, o_en_tf, o_busy, o_done}, 4'b0000);

    // k=3 with lane value = beat index + 1, and a second start during FEED
    // that must be ignored.
    for (int j = 0; j <= 14; j++) begin
      logic [7:0] b;
      b = (j >= 1 && j <= 3) ? 8'(j) : 8'd0;
      applyStimulus((j == 0) || (j == 2), (j == 0) ? 8'd3 : 8'd7,
                    (j >= 1 && j <= 3), {5{b}}, {5{b}});
      if (j >= 5 && j <= 9)
        checkOutput("k3_fmap_lane4", o_fmap[39:32], (j >= 6 && j <= 8) ? j - 5 : 0);
      if (j >= 1 && j <= 5)
        checkOutput("k3_weight_lane0", o_weight[7:0], (j >= 2 && j <= 4) ? j - 1 : 0);
      checkOutput("k3_done", o_done, (j == 13));
      checkOutput("k3_en", o_en_tf, (j >= 1 && j <= 12));
      tick;
    end

    // Reset in the middle of FLUSH abandons the pass.
    for (int j = 0; j < 5; j++) begin
      applyStimulus(j == 0, 8'd1, j == 1, 40'hA5A5A5A5A5, 40'h5A5A5A5A5A);
      tick;
    end
    applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    checkOutput("flush_before_rst", {o_en_tf, o_fmap[31:24]}, {1'b1, 8'hA5});
    rst = 1'b1;
    #1;
    checkOutput("rst_async_outputs",
                {o_fmap, o_weight, s_ready, o_en_tf, o_busy, o_done}, '0);
    tick;
    rst = 1'b0;
    begin
      int dones;
      dones = 0;
      for (int j = 0; j < 15; j++) begin
        tick;
        dones += o_done;
        if (j == 0) checkOutput("rst_drained", {o_fmap, o_weight}, '0);
      end
      checkOutput("rst_no_done", dones, 0);
    end
    for (int j = 0; j <= 12; j++) begin
      applyStimulus(j == 0, 8'd1, j == 1, 40'h0102030405, 40'h0607080910);
      checkOutput("after_rst_done", o_done, (j == 11));
      tick;
    end

    // Table of pass shapes with hand-derived timing.
    for (int i = 0; i < 8; i++) begin
      int done_at, en_cnt, rdy_cnt;
      done_at = -1;
      en_cnt  = 0;
      rdy_cnt = 0;
      for (int j = 0; j < 64 && done_at < 0; j++) begin
        logic v;
        v = (j >= 1 && j <= 16) ? vecs[i].vmask[j-1] : 1'b0;
        applyStimulus(j == 0, vecs[i].k, v, 40'(j * 3), 40'(j * 7));
        if (o_done && done_at < 0) done_at = j;
        en_cnt  += o_en_tf;
        rdy_cnt += s_ready;
        tick;
      end
      applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
      checkOutput($sformatf("vec%0d_done", i), done_at, vecs[i].done_off);
      checkOutput($sformatf("vec%0d_en", i), en_cnt, vecs[i].en_cycles);
      checkOutput($sformatf("vec%0d_ready", i), rdy_cnt, vecs[i].rdy_cycles);
`ifdef TILE_FEEDER_BUBBLE_CNT_EN
      checkOutput($sformatf("vec%0d_bubbles", i), o_bubble_cnt, vecs[i].bubbles);
`endif
    end

    // Randomized passes against the timeline model.
    for (int p = 0; p < 30; p++) runRandomPass();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
